shift_ctrl: RTL and testbench
=============================

# shift_ctrl

Sequencer/arbiter for a single `shift_register` instance, time-sharing it between a transmit requester (parallel word → serial) and a receive requester (serial → parallel word). It drives the register's `en`/`load`/`direction`/`in`/`parallel_in` pins and reads back `parallel_out`. Arbitration is round-robin. Bit rate is set by a cycle divider. It sits between the register and the word-level logic of the serial link.

## Interface
- `WIDTH`, 8: word width; must match the attached `shift_register`.
- `BIT_DIV`, 1: clock cycles per serial bit (≥1).
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `tx_valid` in 1: TX word offered.
- `tx_data` in WIDTH: TX word.
- `tx_lsb_first` in 1: TX bit order; sampled at handshake.
- `tx_ready` out 1: controller accepts a TX word.
- `rx_start` in 1: RX request; level, held until `rx_busy` rises.
- `rx_lsb_first` in 1: RX bit order; sampled at grant.
- `rx_busy` out 1: RX in progress.
- `rx_valid` out 1: one-cycle pulse, `rx_data` updated.
- `rx_data` out WIDTH: last received word; held until the next RX completes.
- `serial_in` in 1: RX serial line.
- `serial_out` out 1: TX serial line. 0 when not transmitting.
- `serial_active` out 1: high while a TX bit is on `serial_out`.
- `sr_en`, `sr_load`, `sr_direction`, `sr_in` out 1: register controls.
- `sr_parallel_in` out WIDTH: register load data.
- `sr_parallel_out` in WIDTH: register contents.

## Operation
- Register semantics: `sr_en`=1 with `sr_load`=1 loads `sr_parallel_in`. `sr_direction`=0 shifts toward the MSB, with `sr_in` entering bit 0. `sr_direction`=1 shifts toward the LSB, with `sr_in` entering bit WIDTH-1.
- States: IDLE, LOAD, TX_SHIFT, RX_SHIFT, RX_DONE.
- `tx_ready` = (state==IDLE) & ~(rx_start & prio==RX). `tx_ready` is 0 during reset.
- IDLE grant:
  - TX handshake (`tx_valid & tx_ready`): capture data and order → LOAD; set prio=RX.
  - Otherwise, if `rx_start`: capture order → RX_SHIFT; set prio=TX.
  - prio matters only when both requests arrive in the same cycle.
- LOAD (1 cycle): `sr_en`=`sr_load`=1, `sr_parallel_in`=captured word, `sr_direction`=order → TX_SHIFT.
- TX_SHIFT:
  - Bit counter 0..WIDTH-1; divider 0..BIT_DIV-1.
  - MSB-first: `sr_direction`=0, `serial_out`=`sr_parallel_out[WIDTH-1]`.
  - LSB-first: `sr_direction`=1, `serial_out`=`sr_parallel_out[0]`.
  - `sr_in`=0.
  - On the last divider cycle: pulse `sr_en` if bit<WIDTH-1; on the last bit, go to IDLE.
- RX_SHIFT:
  - MSB-first uses `sr_direction`=0; LSB-first uses 1.
  - On the last divider cycle of each bit: `sr_en`=1, `sr_in`=`serial_in`.
  - After WIDTH samples → RX_DONE.
- RX_DONE (1 cycle): `rx_data`←`sr_parallel_out`, `rx_valid`←1 (registered) → IDLE.
- `rx_start` is ignored while not in IDLE. `tx_valid` is ignored unless `tx_ready`.
- `sr_load`=0 outside LOAD. `sr_en`=0 except the pulses above.

## Timing
- Reset (async, `rst`=0): state IDLE, prio=TX, counters 0. Every output is 0, including `rx_data`.
- Reset mid-transfer: the transfer is abandoned with no `rx_valid`, and outputs are 0 immediately. Register contents are left to the register's own reset.
- TX with handshake at cycle T:
  - LOAD at T+1.
  - Bit k is on `serial_out` during cycles T+2+k·BIT_DIV … T+1+(k+1)·BIT_DIV.
  - `tx_ready` returns high at T+2+WIDTH·BIT_DIV.
- RX with grant at cycle T:
  - `rx_busy` high from T+1 through RX_DONE.
  - Sample k is taken on the edge ending cycle T+(k+1)·BIT_DIV.
  - `rx_valid` is high in cycle T+WIDTH·BIT_DIV+2, with `rx_data` valid the same cycle.
- Back-to-back: a new grant can occur in the first IDLE cycle after a transfer.

## Test plan
- Reset: hold `rst`=0 for 5 cycles, then release → all outputs 0 during reset; `tx_ready`=1 on the first cycle after release.
- TX MSB-first, WIDTH=8, BIT_DIV=1, `tx_data`=0xA5 handshake at T → one `sr_load` at T+1; `serial_out`=1,0,1,0,0,1,0,1 in cycles T+2..T+9; `serial_active` high exactly those 8 cycles; `tx_ready` high again at T+10.
- TX LSB-first, 0xA5, BIT_DIV=3 → bits 1,0,1,0,0,1,0,1 with each bit held 3 cycles; `sr_direction`=1; `tx_ready` back at T+26.
- RX MSB-first, BIT_DIV=1, drive `serial_in`=0,0,1,1,1,1,0,0 → `rx_valid` pulses once, `rx_data`=0x3C. Repeat LSB-first with the same bits → `rx_data`=0x3C.
- Arbitration: `tx_valid` and `rx_start` both high from reset → TX served first. Keep both asserted → RX, then TX, alternating; neither requester is starved.
- Reset mid-RX after 4 bits → no `rx_valid`, `rx_busy`=0 at once; a following full RX delivers a correct word.

Source files
------------

// File: rtl/shift_ctrl.sv
// shift_ctrl: round-robin sequencer that time-shares one shift_register
// between a word transmitter (parallel -> serial) and a word receiver
// (serial -> parallel), with a programmable cycles-per-bit divider.
module shift_ctrl #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned BIT_DIV = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx_valid,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_lsb_first,
    output logic             tx_ready,
    input  logic             rx_start,
    input  logic             rx_lsb_first,
    output logic             rx_busy,
    output logic             rx_valid,
    output logic [WIDTH-1:0] rx_data,
    input  logic             serial_in,
    output logic             serial_out,
    output logic             serial_active,
    output logic             sr_en,
    output logic             sr_load,
    output logic             sr_direction,
    output logic             sr_in,
    output logic [WIDTH-1:0] sr_parallel_in,
    input  logic [WIDTH-1:0] sr_parallel_out
);

    localparam int unsigned BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned DIV_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        TX_SHIFT,
        RX_SHIFT,
        RX_DONE
    } state_t;

    typedef enum logic {
        PRIO_TX,
        PRIO_RX
    } prio_t;

    state_t           state;
    prio_t            prio;
    logic [BIT_W-1:0] bit_cnt;
    logic [DIV_W-1:0] div_cnt;
    logic [WIDTH-1:0] tx_word;
    logic             tx_order;
    logic             rx_order;
    logic [WIDTH-1:0] rx_data_q;
    logic             rx_valid_q;

    logic div_last;
    logic bit_last;
    logic tx_take;

    assign div_last = (div_cnt == DIV_LAST);
    assign bit_last = (bit_cnt == BIT_LAST);

    // TX may only be accepted in IDLE, and yields when RX holds the turn and is asking.
    // Gating with rst keeps tx_ready low while reset is asserted even though state is IDLE.
    assign tx_ready = rst & (state == IDLE) & ~(rx_start & (prio == PRIO_RX));
    assign tx_take  = tx_valid & tx_ready;

    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;

    // Sequencer: grant, bit/divider counting and RX word capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            prio       <= PRIO_TX;
            bit_cnt    <= '0;
            div_cnt    <= '0;
            tx_word    <= '0;
            tx_order   <= 1'b0;
            rx_order   <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    div_cnt <= '0;
                    if (tx_take) begin
                        tx_word  <= tx_data;
                        tx_order <= tx_lsb_first;
                        prio     <= PRIO_RX;
                        state    <= LOAD;
                    end else if (rx_start) begin
                        rx_order <= rx_lsb_first;
                        prio     <= PRIO_TX;
                        state    <= RX_SHIFT;
                    end
                end
                LOAD: begin
                    state <= TX_SHIFT;
                end
                TX_SHIFT, RX_SHIFT: begin
                    if (div_last) begin
                        div_cnt <= '0;
                        if (bit_last) begin
                            bit_cnt <= '0;
                            state   <= (state == TX_SHIFT) ? IDLE : RX_DONE;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                RX_DONE: begin
                    rx_data_q  <= sr_parallel_out;
                    rx_valid_q <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Register pin drive and serial line decode. These follow the state directly
    // because serial_out must reflect the register contents in the same cycle.
    always_comb begin
        sr_en          = 1'b0;
        sr_load        = 1'b0;
        sr_direction   = 1'b0;
        sr_in          = 1'b0;
        sr_parallel_in = '0;
        serial_out     = 1'b0;
        serial_active  = 1'b0;
        rx_busy        = 1'b0;
        case (state)
            LOAD: begin
                sr_en          = 1'b1;
                sr_load        = 1'b1;
                sr_direction   = tx_order;
                sr_parallel_in = tx_word;
            end
            TX_SHIFT: begin
                sr_direction  = tx_order;
                sr_en         = div_last & ~bit_last;
                serial_active = 1'b1;
                serial_out    = tx_order ? sr_parallel_out[0] : sr_parallel_out[WIDTH-1];
            end
            RX_SHIFT: begin
                sr_direction = rx_order;
                sr_en        = div_last;
                sr_in        = div_last & serial_in;
                rx_busy      = 1'b1;
            end
            RX_DONE: begin
                rx_busy = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_shift_ctrl.sv
// tb_shift_ctrl: directed bench for shift_ctrl. Two controllers share the
// stimulus: dut_a with BIT_DIV=1 and dut_b with BIT_DIV=3, each driving its
// own behavioural shift register.
module tb_shift_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_lsb_first;
    logic       rx_start;
    logic       rx_lsb_first;
    logic       serial_in;

    logic       a_tx_ready, a_rx_busy, a_rx_valid, a_serial_out, a_serial_active;
    logic       a_sr_en, a_sr_load, a_sr_direction, a_sr_in;
    logic [7:0] a_rx_data, a_sr_parallel_in, a_q;

    logic       b_tx_ready, b_rx_busy, b_rx_valid, b_serial_out, b_serial_active;
    logic       b_sr_en, b_sr_load, b_sr_direction, b_sr_in;
    logic [7:0] b_rx_data, b_sr_parallel_in, b_q;

    logic [24:0] a_all;
    logic [24:0] b_all;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    assign a_all = {a_tx_ready, a_rx_busy, a_rx_valid, a_rx_data, a_serial_out, a_serial_active,
                    a_sr_en, a_sr_load, a_sr_direction, a_sr_in, a_sr_parallel_in};
    assign b_all = {b_tx_ready, b_rx_busy, b_rx_valid, b_rx_data, b_serial_out, b_serial_active,
                    b_sr_en, b_sr_load, b_sr_direction, b_sr_in, b_sr_parallel_in};

    shift_ctrl #(.WIDTH(8), .BIT_DIV(1)) dut_a (
        .clk(clk), .rst(rst),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_lsb_first(tx_lsb_first), .tx_ready(a_tx_ready),
        .rx_start(rx_start), .rx_lsb_first(rx_lsb_first), .rx_busy(a_rx_busy),
        .rx_valid(a_rx_valid), .rx_data(a_rx_data),
        .serial_in(serial_in), .serial_out(a_serial_out), .serial_active(a_serial_active),
        .sr_en(a_sr_en), .sr_load(a_sr_load), .sr_direction(a_sr_direction), .sr_in(a_sr_in),
        .sr_parallel_in(a_sr_parallel_in), .sr_parallel_out(a_q)
    );

    shift_ctrl #(.WIDTH(8), .BIT_DIV(3)) dut_b (
        .clk(clk), .rst(rst),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_lsb_first(tx_lsb_first), .tx_ready(b_tx_ready),
        .rx_start(rx_start), .rx_lsb_first(rx_lsb_first), .rx_busy(b_rx_busy),
        .rx_valid(b_rx_valid), .rx_data(b_rx_data),
        .serial_in(serial_in), .serial_out(b_serial_out), .serial_active(b_serial_active),
        .sr_en(b_sr_en), .sr_load(b_sr_load), .sr_direction(b_sr_direction), .sr_in(b_sr_in),
        .sr_parallel_in(b_sr_parallel_in), .sr_parallel_out(b_q)
    );

    // Behavioural shift register for dut_a.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) a_q <= '0;
        else if (a_sr_en) begin
            if (a_sr_load)            a_q <= a_sr_parallel_in;
            else if (!a_sr_direction) a_q <= {a_q[6:0], a_sr_in};
            else                      a_q <= {a_sr_in, a_q[7:1]};
        end
    end

    // Behavioural shift register for dut_b.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) b_q <= '0;
        else if (b_sr_en) begin
            if (b_sr_load)            b_q <= b_sr_parallel_in;
            else if (!b_sr_direction) b_q <= {b_q[6:0], b_sr_in};
            else                      b_q <= {b_sr_in, b_q[7:1]};
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        repeat (n) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // Receive one word on dut_a; seq[7] is the first bit on the line.
    task automatic rx_word(input logic [7:0] seq, input logic lsb, input logic [7:0] exp);
        cyc();
        rx_start     = 1'b1;
        rx_lsb_first = lsb;
        @(negedge clk);
        check("rx_grant_idle", a_rx_busy, 0);
        for (int k = 0; k < 8; k++) begin
            cyc();
            rx_start  = 1'b0;
            serial_in = seq[7-k];
            @(negedge clk);
            check("rx_busy", a_rx_busy, 1);
            check("rx_dir", a_sr_direction, lsb);
            check("rx_sample_en", a_sr_en, 1);
            check("rx_no_early_valid", a_rx_valid, 0);
        end
        cyc();
        @(negedge clk);
        check("rx_done_busy", a_rx_busy, 1);
        check("rx_done_novalid", a_rx_valid, 0);
        cyc();
        @(negedge clk);
        check("rx_valid", a_rx_valid, 1);
        check("rx_data", a_rx_data, exp);
        check("rx_busy_end", a_rx_busy, 0);
        cyc();
        @(negedge clk);
        check("rx_valid_pulse", a_rx_valid, 0);
        check("rx_data_hold", a_rx_data, exp);
    endtask

    initial begin
        logic [7:0] word;
        rst          = 1'b0;
        tx_valid     = 1'b0;
        tx_data      = '0;
        tx_lsb_first = 1'b0;
        rx_start     = 1'b0;
        rx_lsb_first = 1'b0;
        serial_in    = 1'b0;

        // Reset: all outputs low, ready on first cycle after release
        repeat (5) begin
            @(negedge clk);
            check("reset_outs_a", a_all, 0);
            check("reset_outs_b", b_all, 0);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("ready_after_reset", a_tx_ready, 1);

        // TX MSB-first 0xA5, BIT_DIV=1
        word = 8'hA5;
        cyc();
        tx_valid = 1'b1;
        tx_data = word;
        tx_lsb_first = 1'b0;
        @(negedge clk);
        check("tx_hs_ready", a_tx_ready, 1);
        cyc();
        tx_valid = 1'b0;
        @(negedge clk);
        check("load_pulse", {a_sr_en, a_sr_load, a_sr_direction}, 3'b110);
        check("load_data", a_sr_parallel_in, 8'hA5);
        check("load_inactive", a_serial_active, 0);
        for (int k = 0; k < 8; k++) begin
            cyc();
            @(negedge clk);
            check("tx_msb_bit", a_serial_out, word[7-k]);
            check("tx_active", a_serial_active, 1);
            check("tx_noload", a_sr_load, 0);
            check("tx_shift_en", a_sr_en, (k < 7) ? 1 : 0);
            check("tx_busy_ready", a_tx_ready, 0);
        end
        cyc();
        @(negedge clk);
        check("tx_ready_back", a_tx_ready, 1);
        check("tx_idle_line", {a_serial_active, a_serial_out}, 0);

        // TX LSB-first 0xA5, BIT_DIV=3 on dut_b
        do_reset(2);
        cyc();
        tx_valid = 1'b1;
        tx_data = word;
        tx_lsb_first = 1'b1;
        @(negedge clk);
        check("txb_hs_ready", b_tx_ready, 1);
        cyc();
        tx_valid = 1'b0;
        @(negedge clk);
        check("txb_load_pulse", {b_sr_en, b_sr_load, b_sr_direction}, 3'b111);
        for (int k = 0; k < 24; k++) begin
            cyc();
            @(negedge clk);
            check("txb_lsb_bit", b_serial_out, word[k/3]);
            check("txb_dir", b_sr_direction, 1);
            check("txb_active", b_serial_active, 1);
            check("txb_shift_en", b_sr_en, ((k % 3 == 2) && (k / 3 < 7)) ? 1 : 0);
            check("txb_busy_ready", b_tx_ready, 0);
        end
        cyc();
        @(negedge clk);
        check("txb_ready_back", b_tx_ready, 1);
        check("txb_idle_line", b_serial_active, 0);

        // RX MSB-first and LSB-first, BIT_DIV=1
        do_reset(2);
        rx_word(8'b0011_1100, 1'b0, 8'h3C);
        rx_word(8'b0011_1100, 1'b1, 8'h3C);
        rx_word(8'b1101_0000, 1'b1, 8'h0B);

        // Arbitration: both requests held from reset
        rst          = 1'b0;
        tx_valid     = 1'b1;
        tx_data      = 8'h5A;
        tx_lsb_first = 1'b0;
        rx_start     = 1'b1;
        rx_lsb_first = 1'b0;
        serial_in    = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            case (c)
                0:  check("arb_tx_first", a_tx_ready, 1);
                1:  check("arb_tx_load", a_sr_load, 1);
                10: check("arb_tx_yields", {a_tx_ready, a_rx_busy}, 2'b00);
                11: check("arb_rx_granted", a_rx_busy, 1);
                19: check("arb_rx_done", {a_rx_busy, a_rx_valid}, 2'b10);
                20: begin
                    check("arb_rx_valid", a_rx_valid, 1);
                    check("arb_rx_data", a_rx_data, 8'hFF);
                    check("arb_tx_turn", a_tx_ready, 1);
                end
                21: check("arb_tx_load2", {a_sr_load, a_rx_busy}, 2'b10);
                30: check("arb_rx_turn", a_tx_ready, 0);
                31: check("arb_rx_granted2", a_rx_busy, 1);
                default: ;
            endcase
            cyc();
        end

        // Reset in the middle of a receive
        tx_valid = 1'b0;
        rx_start = 1'b0;
        do_reset(2);
        cyc();
        rx_start = 1'b1;
        rx_lsb_first = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            rx_start  = 1'b0;
            serial_in = k[0];
        end
        @(negedge clk);
        check("abort_pre_busy", a_rx_busy, 1);
        rst = 1'b0;
        #1;
        check("abort_busy", a_rx_busy, 0);
        check("abort_outs", a_all, 0);
        repeat (3) begin
            @(negedge clk);
            check("abort_novalid", a_rx_valid, 0);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("abort_idle", {a_rx_busy, a_rx_valid}, 2'b00);
        rx_word(8'b1001_0110, 1'b0, 8'h96);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
